// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register. SkidEn=1 adds a skid entry so ready_o comes
// straight from a flop; SkidEn=0 is a single entry with pass-through ready.
module pipe_stage_reg #(
  parameter int Width  = 64,
  parameter bit SkidEn = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o,
  output logic [1:0]       count_o
);

  logic             main_valid_q, main_valid_d;
  logic [Width-1:0] main_data_q,  main_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [Width-1:0] skid_data_q,  skid_data_d;
  logic             ready_q,      ready_d;
  logic             fire_in, fire_out;

  assign ready_o  = SkidEn ? ready_q : (!main_valid_q | ready_i);
  assign fire_in  = valid_i & ready_o & !flush_i;
  assign fire_out = main_valid_q & ready_i;
  assign valid_o  = main_valid_q;
  assign data_o   = main_data_q;
  assign count_o  = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush_i) begin
      // Only valid bits are dropped; stale data is harmless once invalid.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (fire_out) begin
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (fire_in) begin
        main_data_d  = data_i;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (fire_in) begin
      if (!main_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = data_i;
      end else if (SkidEn) begin
        skid_valid_d = 1'b1;
        skid_data_d  = data_i;
      end
    end
    // With skid occupied ready_o is low, so skid never holds with a fire_in.
    ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      ready_q      <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      ready_q      <= ready_d;
    end
  end

  a_skid_implies_main: assert property (@(posedge clk_i) disable iff (rst_i)
    skid_valid_q |-> main_valid_q);

  a_stall_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_o & !ready_i & !flush_i) |=> (valid_o && $stable(data_o)));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid instance (a) and single-entry instance (b),
// with an output recorder and an expected-payload queue for ordering checks.
module tb_pipe_stage_reg;
  localparam int W = 16;

  logic clk = 1'b0, rst = 1'b1;
  logic fa = 0, va = 0, ra = 0, fb = 0, vb = 0, rb = 0;
  logic [W-1:0] da = '0, db = '0;
  logic rdy_a, vo_a, rdy_b, vo_b;
  logic [W-1:0] do_a, do_b;
  logic [1:0] cnt_a, cnt_b;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_mem [0:255];
  int got_wr = 0;
  int checks = 0, errors = 0;

  pipe_stage_reg #(.Width(W), .SkidEn(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(fa), .valid_i(va), .ready_o(rdy_a),
    .data_i(da), .valid_o(vo_a), .ready_i(ra), .data_o(do_a), .count_o(cnt_a));

  pipe_stage_reg #(.Width(W), .SkidEn(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(fb), .valid_i(vb), .ready_o(rdy_b),
    .data_i(db), .valid_o(vo_b), .ready_i(rb), .data_o(do_b), .count_o(cnt_b));

  always #5 clk = ~clk;

  // Record every payload dut_a hands downstream.
  always @(negedge clk) begin
    if (!rst && vo_a && ra && got_wr < 256) begin
      got_mem[got_wr] <= do_a;
      got_wr <= got_wr + 1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (vo_a !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", vo_a); end
    checks++; if (cnt_a !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", cnt_a); end
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b exp 1", rdy_a); end
    checks++; if (do_a !== '0) begin errors++; $display("FAIL reset_data got %0h exp 0", do_a); end
    checks++; if (vo_b !== 1'b0) begin errors++; $display("FAIL reset_valid_b got %0b exp 0", vo_b); end
    checks++; if (rdy_b !== 1'b1) begin errors++; $display("FAIL reset_ready_b got %0b exp 1", rdy_b); end
    tick(); rst = 0;
    @(negedge clk);
    checks++; if (vo_a !== 1'b0) begin errors++; $display("FAIL post_reset_valid got %0b exp 0", vo_a); end
  endtask

  task automatic test_stream();
    ra = 1;
    for (int i = 1; i <= 4; i++) begin
      tick(); va = 1; da = W'(i); exp_q.push_back(W'(i));
      @(negedge clk);
      if (i > 1) begin
        checks++; if (vo_a !== 1'b1) begin errors++; $display("FAIL stream_valid i=%0d got %0b exp 1", i, vo_a); end
        checks++; if (do_a !== W'(i-1)) begin errors++; $display("FAIL stream_data i=%0d got %0h exp %0h", i, do_a, i-1); end
        checks++; if (cnt_a !== 2'd1) begin errors++; $display("FAIL stream_count i=%0d got %0d exp 1", i, cnt_a); end
      end
    end
    tick(); va = 0;
    @(negedge clk);
    checks++; if (do_a !== W'(4) || vo_a !== 1'b1) begin errors++; $display("FAIL stream_last got %0h/%0b exp 4/1", do_a, vo_a); end
    tick();
    @(negedge clk);
    checks++; if (vo_a !== 1'b0 || cnt_a !== 2'd0) begin errors++; $display("FAIL stream_drain got %0b/%0d exp 0/0", vo_a, cnt_a); end
  endtask

  task automatic test_backpressure();
    tick(); ra = 0; va = 1; da = 'hA; exp_q.push_back('hA);
    @(negedge clk);
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL bp_ready0 got %0b exp 1", rdy_a); end
    tick(); da = 'hB; exp_q.push_back('hB);
    @(negedge clk);
    checks++; if (cnt_a !== 2'd1 || do_a !== W'('hA)) begin errors++; $display("FAIL bp_one got %0d/%0h exp 1/a", cnt_a, do_a); end
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %0b exp 1", rdy_a); end
    tick(); va = 0;
    @(negedge clk);
    checks++; if (cnt_a !== 2'd2) begin errors++; $display("FAIL bp_count2 got %0d exp 2", cnt_a); end
    checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %0b exp 0", rdy_a); end
    checks++; if (do_a !== W'('hA)) begin errors++; $display("FAIL bp_hold got %0h exp a", do_a); end
    tick();
    @(negedge clk);
    checks++; if (do_a !== W'('hA) || cnt_a !== 2'd2) begin errors++; $display("FAIL bp_stall got %0h/%0d exp a/2", do_a, cnt_a); end
    tick(); ra = 1;
    @(negedge clk);
    checks++; if (do_a !== W'('hA) || vo_a !== 1'b1 || rdy_a !== 1'b0) begin
      errors++; $display("FAIL bp_release got %0h/%0b/%0b exp a/1/0", do_a, vo_a, rdy_a); end
    tick();
    @(negedge clk);
    checks++; if (do_a !== W'('hB) || cnt_a !== 2'd1) begin errors++; $display("FAIL bp_second got %0h/%0d exp b/1", do_a, cnt_a); end
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %0b exp 1", rdy_a); end
    tick();
    @(negedge clk);
    checks++; if (vo_a !== 1'b0 || cnt_a !== 2'd0) begin errors++; $display("FAIL bp_drain got %0b/%0d exp 0/0", vo_a, cnt_a); end
  endtask

  task automatic test_flush();
    tick(); ra = 0; va = 1; da = 'h11;
    tick(); da = 'h12;
    tick(); fa = 1; va = 1; da = 'hC;
    @(negedge clk);
    checks++; if (cnt_a !== 2'd2) begin errors++; $display("FAIL flush_pre got %0d exp 2", cnt_a); end
    tick(); fa = 1; va = 1; ra = 1; da = 'hD;
    @(negedge clk);
    checks++; if (vo_a !== 1'b0 || cnt_a !== 2'd0) begin errors++; $display("FAIL flush_clear got %0b/%0d exp 0/0", vo_a, cnt_a); end
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b exp 1", rdy_a); end
    tick(); fa = 0; va = 0;
    @(negedge clk);
    checks++; if (vo_a !== 1'b0 || cnt_a !== 2'd0) begin errors++; $display("FAIL flush_drop got %0b/%0d exp 0/0", vo_a, cnt_a); end
    tick(); tick();
    @(negedge clk);
    checks++; if (vo_a !== 1'b0) begin errors++; $display("FAIL flush_quiet got %0b exp 0", vo_a); end
  endtask

  task automatic test_noskid();
    tick(); rb = 0; vb = 1; db = 'h7;
    @(negedge clk);
    checks++; if (rdy_b !== 1'b1) begin errors++; $display("FAIL ns_ready_empty got %0b exp 1", rdy_b); end
    tick(); db = 'h9;
    @(negedge clk);
    checks++; if (vo_b !== 1'b1 || do_b !== W'('h7)) begin errors++; $display("FAIL ns_hold got %0b/%0h exp 1/7", vo_b, do_b); end
    checks++; if (rdy_b !== 1'b0 || cnt_b !== 2'd1) begin errors++; $display("FAIL ns_stall got %0b/%0d exp 0/1", rdy_b, cnt_b); end
    tick(); rb = 1; db = 'h5;
    @(negedge clk);
    checks++; if (rdy_b !== 1'b1 || do_b !== W'('h7)) begin errors++; $display("FAIL ns_pass got %0b/%0h exp 1/7", rdy_b, do_b); end
    tick(); vb = 0;
    @(negedge clk);
    checks++; if (do_b !== W'('h5) || vo_b !== 1'b1 || cnt_b !== 2'd1) begin
      errors++; $display("FAIL ns_next got %0h/%0b/%0d exp 5/1/1", do_b, vo_b, cnt_b); end
    tick();
    @(negedge clk);
    checks++; if (vo_b !== 1'b0 || cnt_b !== 2'd0) begin errors++; $display("FAIL ns_drain got %0b/%0d exp 0/0", vo_b, cnt_b); end
  endtask

  task automatic test_back_to_back();
    int m = 0;
    bit fi, fo;
    for (int c = 0; c < 80; c++) begin
      tick(); va = ($urandom_range(0, 3) != 0); ra = ($urandom_range(0, 2) != 0); da = W'($urandom);
      @(negedge clk);
      checks++; if (cnt_a !== 2'(m) || rdy_a !== (m < 2) || vo_a !== (m > 0)) begin
        errors++; $display("FAIL b2b c=%0d got cnt %0d rdy %0b vld %0b exp cnt %0d", c, cnt_a, rdy_a, vo_a, m); end
      fi = va && (m < 2);
      fo = (m > 0) && ra;
      if (fi) exp_q.push_back(da);
      m = m - int'(fo) + int'(fi);
    end
    tick(); va = 0; ra = 1;
    tick(); tick(); tick();
    @(negedge clk);
    checks++; if (vo_a !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b exp 0", vo_a); end
  endtask

  task automatic test_async_reset();
    tick(); ra = 0; va = 1; da = 'h21;
    tick(); da = 'h22;
    tick(); va = 0;
    @(negedge clk);
    checks++; if (cnt_a !== 2'd2) begin errors++; $display("FAIL ar_pre got %0d exp 2", cnt_a); end
    rst = 1; #1;
    checks++; if (vo_a !== 1'b0 || cnt_a !== 2'd0) begin errors++; $display("FAIL ar_immediate got %0b/%0d exp 0/0", vo_a, cnt_a); end
    checks++; if (rdy_a !== 1'b1 || do_a !== '0) begin errors++; $display("FAIL ar_ready_data got %0b/%0h exp 1/0", rdy_a, do_a); end
    tick(); rst = 0; va = 1; da = 'h77; ra = 1; exp_q.push_back('h77);
    @(negedge clk);
    checks++; if (cnt_a !== 2'd0) begin errors++; $display("FAIL ar_empty got %0d exp 0", cnt_a); end
    tick(); va = 0;
    @(negedge clk);
    checks++; if (do_a !== W'('h77) || vo_a !== 1'b1) begin errors++; $display("FAIL ar_first got %0h/%0b exp 77/1", do_a, vo_a); end
    tick(); tick();
    @(negedge clk);
    checks++; if (vo_a !== 1'b0) begin errors++; $display("FAIL ar_drain got %0b exp 0", vo_a); end
  endtask

  task automatic test_ordering();
    logic [W-1:0] e;
    checks++; if (got_wr !== exp_q.size()) begin errors++; $display("FAIL order_count got %0d exp %0d", got_wr, exp_q.size()); end
    for (int i = 0; i < got_wr && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++; if (got_mem[i] !== e) begin errors++; $display("FAIL order_data idx=%0d got %0h exp %0h", i, got_mem[i], e); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_noskid();
    test_back_to_back();
    test_async_reset();
    tick(); tick();
    test_ordering();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter Width, default 64, meaning payload width in bits (sized for a packed stage struct).
REQ-002 SHALL have parameter SkidEn, default 1, meaning 1 = two-entry skid stage with registered ready_o, 0 = single-entry stage with combinational ready_o.
REQ-003 SHALL have port clk_i, input, 1, meaning the single clock; all state on rising edge.
REQ-004 SHALL have port rst_i, input, 1, meaning asynchronous active-high reset.
REQ-005 SHALL have port flush_i, input, 1, meaning discard all held and incoming entries this cycle.
REQ-006 SHALL have port valid_i, input, 1, meaning upstream payload valid.
REQ-007 SHALL have port ready_o, output, 1, meaning stage accepts payload this cycle.
REQ-008 SHALL have port data_i, input, Width, meaning upstream payload.
REQ-009 SHALL have port valid_o, output, 1, meaning downstream payload valid.
REQ-010 SHALL have port ready_i, input, 1, meaning downstream accepts payload.
REQ-011 SHALL have port data_o, output, Width, meaning downstream payload, driven from main register only.
REQ-012 SHALL have port count_o, output, 2, meaning number of held entries (0..2; max 1 when SkidEn=0).

Function
REQ-013 SHALL define fire_in = valid_i & ready_o & !flush_i and fire_out = valid_o & ready_i.
REQ-014 SHALL hold state in main (main_valid, main_data) and, when SkidEn=1, skid (skid_valid, skid_data); skid_valid=1 implies main_valid=1 at all times.
REQ-015 SHALL drive valid_o = main_valid and data_o = main_data; latency input-to-output exactly 1 cycle when stage empty.
REQ-016 SHALL, SkidEn=1, drive ready_o = !skid_valid directly from a flop (no combinational path from ready_i or valid_i).
REQ-017 SHALL, SkidEn=0, drive ready_o = !main_valid | ready_i.
REQ-018 SHALL, when main empty and fire_in, load main with data_i.
REQ-019 SHALL, when fire_out and skid_valid, move skid into main and clear skid_valid in the same edge.
REQ-020 SHALL, when fire_out, !skid_valid and fire_in, load main with data_i (full throughput, one transfer per cycle).
REQ-021 SHALL, when fire_out, !skid_valid and !fire_in, clear main_valid.
REQ-022 SHALL, SkidEn=1, when main_valid, !fire_out and fire_in, capture data_i into skid; payload never overwritten or dropped while valid.
REQ-023 SHALL hold main and skid contents unchanged while valid_o & !ready_i (stall), data_o stable.
REQ-024 SHALL, on flush_i, clear main_valid and skid_valid at next edge regardless of valid_i, ready_i; data_i that cycle is dropped even if ready_o=1.
REQ-025 SHALL have flush_i take priority over every load, move and drain of REQ-018..022.
REQ-026 SHALL keep count_o = main_valid + skid_valid, registered-state derived, and preserve payload ordering (FIFO, no reordering).
REQ-027 SHALL not require data registers to be cleared on flush; only valid bits are cleared.

Reset
REQ-028 SHALL, while rst_i=1, asynchronously force main_valid=0, skid_valid=0, main_data=0, skid_data=0, hence valid_o=0, data_o=0, count_o=0, ready_o=1 (SkidEn=1).
REQ-029 SHALL, on reset asserted mid-transfer, discard all entries; first post-reset accept occurs on first edge with rst_i=0 and fire_in.

Verification
REQ-030 SHALL cover streaming: SkidEn=1, ready_i=1, valid_i=1, data_i=1,2,3,4 on consecutive cycles -> data_o=1,2,3,4 one cycle later each, valid_o continuous, count_o=1.
REQ-031 SHALL cover backpressure: SkidEn=1, feed 0xA,0xB while ready_i=0 -> count_o=2, ready_o=0, data_o=0xA held; raise ready_i -> 0xA then 0xB out, ready_o=1 one cycle after 0xA drains.
REQ-032 SHALL cover flush: count_o=2, assert flush_i with valid_i=1 data_i=0xC -> next cycle valid_o=0, count_o=0, 0xC never appears.
REQ-033 SHALL cover SkidEn=0: valid_o=1, ready_i=0 -> ready_o=0; ready_i=1 same cycle valid_i=1 data_i=0x5 -> ready_o=1, next data_o=0x5.
REQ-034 SHALL cover async reset: assert rst_i between clock edges with count_o=2 -> valid_o=0, count_o=0 immediately, before next edge.
REQ-035 SHALL check continuously by assertion: skid_valid implies main_valid; data_o stable while valid_o & !ready_i & !flush_i.
